// File: rtl/axi_arb_pkg.sv
// Shared types and default AXI widths for the 2:1 read arbiter.
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

package axi_arb_pkg;
  localparam int AXI_ID_W   = `D_ID_WIDTH;
  localparam int AXI_ADDR_W = `D_ADDR_WIDTH;
  localparam int AXI_DATA_W = `D_DATA_WIDTH;
  localparam int NUM_M      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;
endpackage

// File: rtl/axi_rr_arb2.sv
// Two-input round-robin picker: on contention prio names the winner,
// otherwise the lone requester wins. Index 0 when nobody requests.
import axi_arb_pkg::*;

module axi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx
);
  assign gnt_idx = (&req) ? prio : (req[1] & ~req[0]);
endmodule

// File: rtl/axi_rd_arb2.sv
// 2:1 AXI read arbiter. One burst in flight; grant held from AR
// handshake through the RLAST handshake, pointer flips on completion.
import axi_arb_pkg::*;

module axi_rd_arb2 #(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0
  input  logic [ID_W-1:0]   m0_ARID,
  input  logic [ADDR_W-1:0] m0_ARADDR,
  input  logic [7:0]        m0_ARLEN,
  input  logic [2:0]        m0_ARSIZE,
  input  logic [1:0]        m0_ARBURST,
  input  logic [2:0]        m0_ARPROT,
  input  logic              m0_ARVALID,
  output logic              m0_ARREADY,
  output logic [ID_W-1:0]   m0_RID,
  output logic [DATA_W-1:0] m0_RDATA,
  output logic [1:0]        m0_RRESP,
  output logic              m0_RLAST,
  output logic              m0_RVALID,
  input  logic              m0_RREADY,
  // master 1
  input  logic [ID_W-1:0]   m1_ARID,
  input  logic [ADDR_W-1:0] m1_ARADDR,
  input  logic [7:0]        m1_ARLEN,
  input  logic [2:0]        m1_ARSIZE,
  input  logic [1:0]        m1_ARBURST,
  input  logic [2:0]        m1_ARPROT,
  input  logic              m1_ARVALID,
  output logic              m1_ARREADY,
  output logic [ID_W-1:0]   m1_RID,
  output logic [DATA_W-1:0] m1_RDATA,
  output logic [1:0]        m1_RRESP,
  output logic              m1_RLAST,
  output logic              m1_RVALID,
  input  logic              m1_RREADY,
  // slave
  output logic [ID_W-1:0]   s_ARID,
  output logic [ADDR_W-1:0] s_ARADDR,
  output logic [7:0]        s_ARLEN,
  output logic [2:0]        s_ARSIZE,
  output logic [1:0]        s_ARBURST,
  output logic [2:0]        s_ARPROT,
  output logic              s_ARVALID,
  input  logic              s_ARREADY,
  input  logic [ID_W-1:0]   s_RID,
  input  logic [DATA_W-1:0] s_RDATA,
  input  logic [1:0]        s_RRESP,
  input  logic              s_RLAST,
  input  logic              s_RVALID,
  output logic              s_RREADY,
  // status
  output logic              grant,
  output logic              busy,
  output logic              len_err
);

  arb_state_e state;
  logic       prio;
  logic [7:0] beat_cnt;
  logic       gnt_idx;
  logic       ar_hs, r_hs;

  // per-master views packed by index
  logic [NUM_M-1:0][ID_W-1:0]   ar_id;
  logic [NUM_M-1:0][ADDR_W-1:0] ar_addr;
  logic [NUM_M-1:0][7:0]        ar_len;
  logic [NUM_M-1:0][2:0]        ar_size;
  logic [NUM_M-1:0][1:0]        ar_burst;
  logic [NUM_M-1:0][2:0]        ar_prot;
  logic [NUM_M-1:0]             ar_valid;
  logic [NUM_M-1:0]             r_ready;

  logic [NUM_M-1:0]             m_arready, m_rvalid, m_rlast;
  logic [NUM_M-1:0][ID_W-1:0]   m_rid;
  logic [NUM_M-1:0][DATA_W-1:0] m_rdata;
  logic [NUM_M-1:0][1:0]        m_rresp;

  assign ar_id    = {m1_ARID,    m0_ARID};
  assign ar_addr  = {m1_ARADDR,  m0_ARADDR};
  assign ar_len   = {m1_ARLEN,   m0_ARLEN};
  assign ar_size  = {m1_ARSIZE,  m0_ARSIZE};
  assign ar_burst = {m1_ARBURST, m0_ARBURST};
  assign ar_prot  = {m1_ARPROT,  m0_ARPROT};
  assign ar_valid = {m1_ARVALID, m0_ARVALID};
  assign r_ready  = {m1_RREADY,  m0_RREADY};

  axi_rr_arb2 u_rr (
    .req     (ar_valid),
    .prio    (prio),
    .gnt_idx (gnt_idx)
  );

  assign busy = (state != IDLE);

  // slave AR payload follows the owner while a grant is held, zero otherwise
  assign s_ARID    = busy ? ar_id[grant]    : '0;
  assign s_ARADDR  = busy ? ar_addr[grant]  : '0;
  assign s_ARLEN   = busy ? ar_len[grant]   : '0;
  assign s_ARSIZE  = busy ? ar_size[grant]  : '0;
  assign s_ARBURST = busy ? ar_burst[grant] : '0;
  assign s_ARPROT  = busy ? ar_prot[grant]  : '0;
  assign s_ARVALID = (state == ADDR) & ar_valid[grant];
  assign s_RREADY  = (state == DATA) & r_ready[grant];

  assign ar_hs = s_ARVALID & s_ARREADY;
  assign r_hs  = s_RVALID & s_RREADY;

  // per-master return path: only the owner sees the slave, others get zeros
  for (genvar i = 0; i < NUM_M; i++) begin : g_m
    logic own;
    assign own          = busy & (grant == 1'(i));
    assign m_arready[i] = own & (state == ADDR) & s_ARREADY;
    assign m_rvalid[i]  = own & (state == DATA) & s_RVALID;
    assign m_rlast[i]   = own & s_RLAST;
    assign m_rid[i]     = own ? s_RID   : '0;
    assign m_rdata[i]   = own ? s_RDATA : '0;
    assign m_rresp[i]   = own ? s_RRESP : '0;
  end

  assign m0_ARREADY = m_arready[0];
  assign m0_RVALID  = m_rvalid[0];
  assign m0_RLAST   = m_rlast[0];
  assign m0_RID     = m_rid[0];
  assign m0_RDATA   = m_rdata[0];
  assign m0_RRESP   = m_rresp[0];
  assign m1_ARREADY = m_arready[1];
  assign m1_RVALID  = m_rvalid[1];
  assign m1_RLAST   = m_rlast[1];
  assign m1_RID     = m_rid[1];
  assign m1_RDATA   = m_rdata[1];
  assign m1_RRESP   = m_rresp[1];

  // burst FSM: grant in IDLE, AR handshake in ADDR, beats until RLAST in DATA
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      prio     <= 1'b0;
      grant    <= 1'b0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (|ar_valid) begin
          grant <= gnt_idx;
          state <= ADDR;
        end
        ADDR: if (ar_hs) begin
          beat_cnt <= ar_len[grant];
          state    <= DATA;
        end
        DATA: if (r_hs) begin
          if (s_RLAST) begin
            // early RLAST still ends the burst; only flag it
            len_err <= (beat_cnt != '0);
            prio    <= ~grant;
            state   <= IDLE;
          end else begin
            // extra beats past ARLEN keep the counter pinned at zero
            len_err <= (beat_cnt == '0);
            if (beat_cnt != '0) beat_cnt <= beat_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Directed bench for axi_rd_arb2: per-cycle vector table plus
// hand-written back-pressure and reset-mid-burst sequences.
module tb_axi_rd_arb2;
  localparam logic [31:0] D = 32'hDEADBEEF;

  logic        ACLK, ARESETn;
  logic [1:0]  arv, rrdy;
  logic [7:0]  len;
  logic        s_ARREADY, s_RVALID, s_RLAST;
  logic [31:0] s_RDATA;
  logic [3:0]  s_RID;
  logic [1:0]  s_RRESP;

  logic [3:0]  m0_RID, m1_RID, s_ARID;
  logic [31:0] m0_RDATA, m1_RDATA, s_ARADDR;
  logic [1:0]  m0_RRESP, m1_RRESP, s_ARBURST;
  logic [7:0]  s_ARLEN;
  logic [2:0]  s_ARSIZE, s_ARPROT;
  logic        m0_ARREADY, m1_ARREADY, m0_RLAST, m1_RLAST, m0_RVALID, m1_RVALID;
  logic        s_ARVALID, s_RREADY, grant, busy, len_err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_rd_arb2 dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_ARID(4'h1), .m0_ARADDR(32'h100), .m0_ARLEN(len), .m0_ARSIZE(3'd2),
    .m0_ARBURST(2'b01), .m0_ARPROT(3'd0), .m0_ARVALID(arv[0]), .m0_ARREADY(m0_ARREADY),
    .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RVALID(m0_RVALID), .m0_RREADY(rrdy[0]),
    .m1_ARID(4'h2), .m1_ARADDR(32'h200), .m1_ARLEN(len), .m1_ARSIZE(3'd2),
    .m1_ARBURST(2'b01), .m1_ARPROT(3'd0), .m1_ARVALID(arv[1]), .m1_ARREADY(m1_ARREADY),
    .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RVALID(m1_RVALID), .m1_RREADY(rrdy[1]),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_ARPROT(s_ARPROT), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  arv;
    logic        sar, srv, srl;
    logic [7:0]  len;
    logic [31:0] rdata;
    logic        busy, gnt, sarv;
    logic [1:0]  arrdy, rvld;
    logic        srrdy, lerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [1:0] a, logic sar, logic srv, logic srl, logic [7:0] l,
                             logic [31:0] d, logic b, logic g, logic sv, logic [1:0] ar,
                             logic [1:0] rv, logic sr, logic le);
    vec_t r;
    r.arv = a; r.sar = sar; r.srv = srv; r.srl = srl; r.len = l; r.rdata = d;
    r.busy = b; r.gnt = g; r.sarv = sv; r.arrdy = ar; r.rvld = rv; r.srrdy = sr; r.lerr = le;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic sar, input logic srv,
                       input logic srl, input logic [31:0] d, input logic [1:0] rr);
    @(negedge ACLK);
    arv = a; s_ARREADY = sar; s_RVALID = srv; s_RLAST = srl; s_RDATA = d; rrdy = rr;
    #2;
  endtask

  // request from master m alone and complete the AR handshake
  task automatic start_burst(input int m, input logic [7:0] l);
    len = l;
    drive(2'(1 << m), 1'b0, 1'b0, 1'b0, D, 2'b11);
    chk("start idle", busy, 1'b0);
    drive(2'(1 << m), 1'b1, 1'b0, 1'b0, D, 2'b11);
    chk("start grant", grant, 1'(m));
    chk("start s_arvalid", s_ARVALID, 1'b1);
  endtask

  task automatic beat(input int m, input logic [31:0] d, input logic l);
    drive(2'b00, 1'b0, 1'b1, l, d, 2'b11);
    chk("beat rvalid", (m == 0) ? m0_RVALID : m1_RVALID, 1'b1);
    chk("beat rdata", (m == 0) ? m0_RDATA : m1_RDATA, d);
  endtask

  initial begin
    logic [31:0] got[$];
    int bt;
    ARESETn = 1'b0; arv = '0; rrdy = '0; len = '0; s_ARREADY = 0; s_RVALID = 0;
    s_RLAST = 0; s_RDATA = D; s_RID = 4'h5; s_RRESP = 2'b00;

    // contention right after reset: m0 first, then m1, then m0 again
    vecs.push_back(v(2'b11,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b11,1,0,0,1,D,           1,0,1,2'b01,2'b00,0,0));
    vecs.push_back(v(2'b10,0,1,0,1,32'hB0,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b10,0,1,1,1,32'hB1,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b10,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b10,1,0,0,1,D,           1,1,1,2'b10,2'b00,0,0));
    vecs.push_back(v(2'b00,0,1,0,1,32'hC0,      1,1,0,2'b00,2'b10,1,0));
    vecs.push_back(v(2'b00,0,1,1,1,32'hC1,      1,1,0,2'b00,2'b10,1,0));
    vecs.push_back(v(2'b11,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b11,0,0,0,1,D,           1,0,1,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b11,1,0,0,1,D,           1,0,1,2'b01,2'b00,0,0));
    vecs.push_back(v(2'b10,0,1,0,1,32'hD0,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b10,0,1,1,1,32'hD1,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b10,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b10,1,0,0,1,D,           1,1,1,2'b10,2'b00,0,0));
    vecs.push_back(v(2'b00,0,1,0,1,32'hE0,      1,1,0,2'b00,2'b10,1,0));
    vecs.push_back(v(2'b00,0,1,1,1,32'hE1,      1,1,0,2'b00,2'b10,1,0));
    // single m0 request, ARLEN=3, four beats
    vecs.push_back(v(2'b01,0,0,0,3,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b01,1,0,0,3,D,           1,0,1,2'b01,2'b00,0,0));
    vecs.push_back(v(2'b00,0,1,0,3,32'hA0,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b00,0,1,0,3,32'hA1,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b00,0,1,0,3,32'hA2,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b00,0,1,1,3,32'hA3,      1,0,0,2'b00,2'b01,1,0));
    // ARLEN=3 but RLAST on beat 2
    vecs.push_back(v(2'b01,0,0,0,3,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b01,1,0,0,3,D,           1,0,1,2'b01,2'b00,0,0));
    vecs.push_back(v(2'b00,0,1,0,3,32'hF0,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b00,0,1,1,3,32'hF1,      1,0,0,2'b00,2'b01,1,0));
    vecs.push_back(v(2'b00,0,0,0,3,D,           0,0,0,2'b00,2'b00,0,1));
    vecs.push_back(v(2'b00,0,0,0,3,D,           0,0,0,2'b00,2'b00,0,0));
    // ARLEN=1 on m1 but the slave sends three beats
    vecs.push_back(v(2'b10,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));
    vecs.push_back(v(2'b10,1,0,0,1,D,           1,1,1,2'b10,2'b00,0,0));
    vecs.push_back(v(2'b00,0,1,0,1,32'h60,      1,1,0,2'b00,2'b10,1,0));
    vecs.push_back(v(2'b00,0,1,0,1,32'h61,      1,1,0,2'b00,2'b10,1,0));
    vecs.push_back(v(2'b00,0,1,1,1,32'h62,      1,1,0,2'b00,2'b10,1,1));
    vecs.push_back(v(2'b00,0,0,0,1,D,           0,0,0,2'b00,2'b00,0,0));

    // reset state
    repeat (2) @(negedge ACLK);
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst len_err", len_err, 1'b0);
    chk("rst s_arvalid", s_ARVALID, 1'b0);
    chk("rst s_rready", s_RREADY, 1'b0);
    chk("rst arready", {m1_ARREADY, m0_ARREADY}, 2'b00);
    chk("rst rvalid", {m1_RVALID, m0_RVALID}, 2'b00);
    chk("rst s_araddr", s_ARADDR, 32'h0);
    chk("rst m0_rdata", m0_RDATA, 32'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    foreach (vecs[i]) begin
      len = vecs[i].len;
      drive(vecs[i].arv, vecs[i].sar, vecs[i].srv, vecs[i].srl, vecs[i].rdata, 2'b11);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      if (vecs[i].busy) chk($sformatf("v%0d grant", i), grant, vecs[i].gnt);
      chk($sformatf("v%0d s_arvalid", i), s_ARVALID, vecs[i].sarv);
      chk($sformatf("v%0d arready", i), {m1_ARREADY, m0_ARREADY}, vecs[i].arrdy);
      chk($sformatf("v%0d rvalid", i), {m1_RVALID, m0_RVALID}, vecs[i].rvld);
      chk($sformatf("v%0d s_rready", i), s_RREADY, vecs[i].srrdy);
      chk($sformatf("v%0d len_err", i), len_err, vecs[i].lerr);
      if (vecs[i].sarv)
        chk($sformatf("v%0d s_araddr", i), s_ARADDR, vecs[i].gnt ? 32'h200 : 32'h100);
      if (vecs[i].rvld[0]) begin
        chk($sformatf("v%0d m0_rdata", i), m0_RDATA, vecs[i].rdata);
        chk($sformatf("v%0d m1_rdata0", i), m1_RDATA, 32'h0);
      end
      if (vecs[i].rvld[1]) begin
        chk($sformatf("v%0d m1_rdata", i), m1_RDATA, vecs[i].rdata);
        chk($sformatf("v%0d m0_rdata0", i), m0_RDATA, 32'h0);
      end
      if (!vecs[i].busy) begin
        chk($sformatf("v%0d idle s_araddr", i), s_ARADDR, 32'h0);
        chk($sformatf("v%0d idle rdata", i), {m1_RDATA, m0_RDATA}, 64'h0);
      end
    end

    // back-pressure: AR stalled 5 cycles, m1_RREADY toggling
    len = 8'd3;
    drive(2'b10, 1'b0, 1'b0, 1'b0, D, 2'b00);
    chk("bp idle", busy, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(2'b10, 1'b0, 1'b0, 1'b0, D, 2'b00);
      chk("bp s_arvalid", s_ARVALID, 1'b1);
      chk("bp s_araddr", s_ARADDR, 32'h200);
      chk("bp s_arid", s_ARID, 4'h2);
      chk("bp s_arlen", s_ARLEN, 8'd3);
      chk("bp m1_arready", m1_ARREADY, 1'b0);
    end
    drive(2'b10, 1'b1, 1'b0, 1'b0, D, 2'b00);
    chk("bp ar accept", m1_ARREADY, 1'b1);
    bt = 0;
    for (int c = 0; c < 16 && bt < 4; c++) begin
      drive(2'b00, 1'b0, 1'b1, (bt == 3), 32'hBB00 + bt, {c[0], 1'b0});
      chk("bp m1_rvalid", m1_RVALID, 1'b1);
      if (m1_RVALID && rrdy[1]) begin
        got.push_back(m1_RDATA);
        bt++;
      end
    end
    chk("bp beat count", got.size(), 4);
    foreach (got[i]) chk($sformatf("bp beat%0d", i), got[i], 32'hBB00 + i);
    drive(2'b00, 1'b0, 1'b0, 1'b0, D, 2'b00);
    chk("bp done busy", busy, 1'b0);
    chk("bp len_err", len_err, 1'b0);

    // one m0 burst leaves the pointer on m1
    start_burst(0, 8'd0);
    beat(0, 32'h77, 1'b1);

    // reset during beat 2 of 4
    start_burst(0, 8'd3);
    beat(0, 32'hC0, 1'b0);
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hC1, 2'b11);
    ARESETn = 1'b0;
    #1;
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst s_rready", s_RREADY, 1'b0);
    chk("mid rst rvalid", {m1_RVALID, m0_RVALID}, 2'b00);
    chk("mid rst s_arvalid", s_ARVALID, 1'b0);
    @(negedge ACLK);
    arv = '0; s_RVALID = 0; s_RLAST = 0; s_ARREADY = 0;
    ARESETn = 1'b1;
    drive(2'b11, 1'b0, 1'b0, 1'b0, D, 2'b11);
    chk("post rst idle", busy, 1'b0);
    drive(2'b11, 1'b0, 1'b0, 1'b0, D, 2'b11);
    chk("post rst busy", busy, 1'b1);
    chk("post rst grant", grant, 1'b0);
    chk("post rst s_araddr", s_ARADDR, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_arb2.md
# axi_rd_arb2

Two-to-one AXI read-channel arbiter. It shares one AXI slave read port (AR + R channels of an `axi_if` slave side) between two AXI masters. It grants one master per burst using round-robin priority, holds the grant from the AR handshake until the RLAST handshake, and flags bursts whose beat count disagrees with ARLEN. One read transaction is outstanding at a time, so R routing uses the registered grant and IDs pass through unchanged.

## Interface

Parameters:
- ID_W, default `` `D_ID_WIDTH ``: width of ARID and RID.
- ADDR_W, default `` `D_ADDR_WIDTH ``: width of ARADDR.
- DATA_W, default `` `D_DATA_WIDTH ``: width of RDATA.

Ports:
- ACLK  in  1  clock; the only clock in the block.
- ARESETn  in  1  reset, asynchronous, active-low.
- m0_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID  in  ID_W/ADDR_W/8/3/2/3/1  master 0 read address.
- m0_ARREADY  out  1  master 0 address accept.
- m0_RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/DATA_W/2/1/1  master 0 read data.
- m0_RREADY  in  1  master 0 data accept.
- m1_*  same set as m0_*  master 1.
- s_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID  out  as m0  to slave.
- s_ARREADY  in  1  slave address accept.
- s_RID/RDATA/RRESP/RLAST/RVALID  in  as m0  from slave.
- s_RREADY  out  1  to slave.
- grant  out  1  index of the owning master; valid while busy=1.
- busy  out  1  asserted in ADDR or DATA.
- len_err  out  1  one-cycle pulse on a beat-count mismatch.

## Operation

- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any mN_ARVALID=1, register grant and move to ADDR.
  - If both request, the master named by the round-robin pointer `prio` wins.
- ADDR:
  - s_AR* = granted master's AR*, and s_ARVALID = its ARVALID.
  - Granted mN_ARREADY = s_ARREADY; the other master's ARREADY = 0.
  - On s_ARVALID && s_ARREADY: load beat_cnt = ARLEN and move to DATA.
- DATA:
  - Granted master's R* = s_R*, and s_RREADY = its RREADY. The other master sees RVALID=0.
  - Each R handshake with RLAST=0 decrements beat_cnt.
  - On the R handshake with RLAST=1: go to IDLE, set prio = ~grant.
- len_err pulses in the cycle after an R handshake where:
  - RLAST=1 and beat_cnt≠0, or
  - RLAST=0 and beat_cnt==0 (beat_cnt holds at 0; no underflow).
- A length error never aborts the burst. Termination is always on RLAST.
- When there is no grant (IDLE), all s_AR* and m*_R* data fields are driven to 0 and all valid/ready outputs are 0.
- A master's ARVALID that drops before the handshake is an AXI violation and does not need to be handled.

## Timing

- Reset values:
  - state=IDLE, prio=0, grant=0, beat_cnt=0.
  - busy=0, len_err=0.
  - s_ARVALID=0, s_RREADY=0.
  - m0/m1 ARREADY=0, RVALID=0.
  - All data outputs 0.
- Arbitration latency: a request seen in IDLE at edge k gives s_ARVALID=1 from cycle k+1.
- AR and R paths through the block are combinational: zero added latency, full R throughput (one beat per cycle).
- There is one IDLE cycle between consecutive bursts.
- Reset asserted mid-burst: asynchronously return to IDLE with all valids/readies low. The slave-side burst is abandoned; the system resets the slave together with the arbiter.
- Simultaneous requests: when one master releases, the other master waiting is served next (pointer flips on every completion).

## Structure

- Package axi_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e.
  - The AXI width macros, re-exported as localparams.
- Sub-module axi_rr_arb2 is a 2-input round-robin picker with inputs req[1:0] and prio, and output gnt_idx. It is purely combinational.
- The FSM, beat counter and muxes live in the top.

## Test plan

- Single request:
  - Stimulus: m0 ARADDR=0x100, ARLEN=3, slave returns 4 beats with RLAST on beat 4.
  - Required: m0 receives 4 beats; s_ARVALID rises one cycle after m0_ARVALID; m1 sees RVALID=0 throughout; len_err=0.
- Contention:
  - Stimulus: m0 and m1 request in the same cycle after reset.
  - Required: m0 is served first, then m1 after the m0 RLAST handshake plus one IDLE cycle.
  - Then, with both requesting again, m0 wins (prio=0).
- Back-pressure:
  - Stimulus: s_ARREADY held low for 5 cycles; m1_RREADY toggled every other cycle during a 4-beat burst.
  - Required: the AR payload is stable for all 5 cycles; each beat is delivered once; no beat is dropped or duplicated.
- Length error:
  - Stimulus: ARLEN=3 but the slave asserts RLAST on beat 2; then ARLEN=1 and the slave sends 3 beats.
  - Required: len_err pulses once in each case; the arbiter returns to IDLE on RLAST.
- Reset mid-burst:
  - Stimulus: ARESETn driven low during beat 2 of 4.
  - Required: immediately (asynchronously) busy=0, s_RREADY=0, all m*_RVALID=0.
  - After release, the first request is granted to m0.
